// File: rtl/sha256_msg_ctrl.sv
// SHA-256 message controller: pads a byte-length message stream into
// 16-word blocks, feeds the engine FIFO and sequences the engine per block.
module sha256_msg_ctrl (
    input  logic         clk,
    input  logic         rstn,
    input  logic [31:0]  len_i,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic         in_valid_i,
    input  logic [31:0]  in_dat_i,
    output logic         in_ready_o,
    output logic         fifo_wr_en_o,
    output logic [31:0]  fifo_wr_dat_o,
    input  logic         fifo_full_i,
    output logic         eng_rstn_o,
    output logic         eng_start_o,
    input  logic         eng_ready_i,
    input  logic [255:0] eng_hash_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [255:0] hash_o,
    output logic [26:0]  blk_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_ERST, S_FILL, S_START, S_WAIT, S_DONE, S_ABRT
    } state_t;

    state_t         r_state;
    logic [31:0]    r_len;
    logic [26:0]    r_nblk;      // total blocks B for this message
    logic [30:0]    r_nin;       // input words to consume
    logic [3:0]     r_wib;       // word index inside the current block
    logic [1:0]     r_rcnt;      // engine reset pulse length counter
    logic           r_wr_en;
    logic [31:0]    r_wr_dat;
    logic           r_eng_rstn;
    logic           r_eng_start;
    logic           r_busy;
    logic           r_done;
    logic [255:0]   r_hash;
    logic [26:0]    r_blk_cnt;

    logic [30:0]    w_j;
    logic [30:0]    w_p;
    logic [30:0]    w_end;
    logic           w_need;
    logic           w_fire;
    logic           w_more;
    logic [31:0]    w_word;
    logic [26:0]    w_start_nblk;
    logic [30:0]    w_start_nin;

    // B = floor((L+8)/64)+1, split so the +8 carry only depends on L[5:0]
    assign w_start_nblk = {1'b0, len_i[31:6]} + {26'd0, (len_i[5:0] >= 6'd56)} + 27'd1;
    assign w_start_nin  = {1'b0, len_i[31:2]} + {30'd0, |len_i[1:0]};

    assign w_j    = {r_blk_cnt, r_wib};
    assign w_p    = {1'b0, r_len[31:2]};
    assign w_end  = {r_nblk, 4'b0000};
    assign w_need = (w_j < r_nin);
    assign w_more = ({1'b0, r_blk_cnt} + 28'd1) < {1'b0, r_nblk};

    assign in_ready_o = (r_state == S_FILL) && w_need && !fifo_full_i;
    assign w_fire     = (r_state == S_FILL) && !abort_i && !fifo_full_i &&
                        (!w_need || in_valid_i);

    // Content of global word j: data, 0x80 terminator, zero fill, length field
    always_comb begin
        w_word = 32'h0;
        if (w_j == w_end - 31'd1) begin
            w_word = {r_len[28:0], 3'b000};
        end else if (w_j == w_end - 31'd2) begin
            w_word = {29'd0, r_len[31:29]};
        end else if (w_j < w_p) begin
            w_word = in_dat_i;
        end else if (w_j == w_p) begin
            case (r_len[1:0])
                2'd0:    w_word = 32'h8000_0000;
                2'd1:    w_word = {in_dat_i[31:24], 24'h80_0000};
                2'd2:    w_word = {in_dat_i[31:16], 16'h8000};
                default: w_word = {in_dat_i[31:8], 8'h80};
            endcase
        end
    end

    // Control FSM with registered outputs; abort preempts every busy state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_len       <= 32'd0;
            r_nblk      <= 27'd0;
            r_nin       <= 31'd0;
            r_wib       <= 4'd0;
            r_rcnt      <= 2'd0;
            r_wr_en     <= 1'b0;
            r_wr_dat    <= 32'd0;
            r_eng_rstn  <= 1'b0;
            r_eng_start <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_hash      <= 256'd0;
            r_blk_cnt   <= 27'd0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            if (abort_i && r_state != S_IDLE && r_state != S_ABRT) begin
                r_state     <= S_ABRT;
                r_eng_rstn  <= 1'b0;
                r_eng_start <= 1'b0;
                r_rcnt      <= 2'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_eng_rstn <= 1'b1;
                        if (start_i) begin
                            r_len      <= len_i;
                            r_nblk     <= w_start_nblk;
                            r_nin      <= w_start_nin;
                            r_blk_cnt  <= 27'd0;
                            r_eng_rstn <= 1'b0;
                            r_rcnt     <= 2'd0;
                            r_busy     <= 1'b1;
                            r_state    <= S_ERST;
                        end
                    end
                    S_ERST: begin
                        if (r_rcnt == 2'd0) begin
                            r_rcnt <= 2'd1;
                        end else if (r_rcnt == 2'd1) begin
                            r_rcnt     <= 2'd2;
                            r_eng_rstn <= 1'b1;
                        end else if (eng_ready_i) begin
                            r_wib   <= 4'd0;
                            r_state <= S_FILL;
                        end
                    end
                    S_FILL: begin
                        if (w_fire) begin
                            r_wr_en  <= 1'b1;
                            r_wr_dat <= w_word;
                            r_wib    <= r_wib + 4'd1;
                            if (r_wib == 4'd15) begin
                                r_eng_start <= 1'b1;
                                r_state     <= S_START;
                            end
                        end
                    end
                    S_START: begin
                        if (!eng_ready_i) begin
                            r_eng_start <= 1'b0;
                            r_state     <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (eng_ready_i) begin
                            r_blk_cnt <= r_blk_cnt + 27'd1;
                            if (w_more) begin
                                r_wib   <= 4'd0;
                                r_state <= S_FILL;
                            end else begin
                                r_hash  <= eng_hash_i;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    S_ABRT: begin
                        if (r_rcnt == 2'd0) begin
                            r_rcnt <= 2'd1;
                        end else begin
                            r_eng_rstn <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign fifo_wr_en_o  = r_wr_en;
    assign fifo_wr_dat_o = r_wr_dat;
    assign eng_rstn_o    = r_eng_rstn;
    assign eng_start_o   = r_eng_start;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign hash_o        = r_hash;
    assign blk_cnt_o     = r_blk_cnt;

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Directed bench for sha256_msg_ctrl with a behavioural engine/FIFO model.
module tb_sha256_msg_ctrl;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [31:0]  len_i = 32'd0;
    logic         start_i = 1'b0;
    logic         abort_i = 1'b0;
    logic         in_valid_i = 1'b0;
    logic [31:0]  in_dat_i = 32'd0;
    logic         in_ready_o;
    logic         fifo_wr_en_o;
    logic [31:0]  fifo_wr_dat_o;
    logic         fifo_full_i = 1'b0;
    logic         eng_rstn_o;
    logic         eng_start_o;
    logic         eng_ready_i = 1'b0;
    logic [255:0] eng_hash_i = 256'd0;
    logic         busy_o;
    logic         done_o;
    logic [255:0] hash_o;
    logic [26:0]  blk_cnt_o;

    localparam logic [255:0] H_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] H_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] H_BP    = {4{64'h0123456789ABCDEF}};
    localparam logic [255:0] H_JUNK  = {8{32'hDEADBEEF}};

    always #5 clk = ~clk;

    sha256_msg_ctrl dut (
        .clk(clk), .rstn(rstn), .len_i(len_i), .start_i(start_i), .abort_i(abort_i),
        .in_valid_i(in_valid_i), .in_dat_i(in_dat_i), .in_ready_o(in_ready_o),
        .fifo_wr_en_o(fifo_wr_en_o), .fifo_wr_dat_o(fifo_wr_dat_o), .fifo_full_i(fifo_full_i),
        .eng_rstn_o(eng_rstn_o), .eng_start_o(eng_start_o), .eng_ready_i(eng_ready_i),
        .eng_hash_i(eng_hash_i), .busy_o(busy_o), .done_o(done_o), .hash_o(hash_o),
        .blk_cnt_o(blk_cnt_o)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] msg [0:63];
    int          nin = 0, idx = 0, bp_mode = 0, cyc = 0;
    int          consumed = 0, done_cnt = 0, start_cnt = 0, rstn_low = 0, eng_cnt = 0;
    bit          took = 0, prev_start = 0;
    logic [31:0] wq[$];

    // Environment: message source, FIFO monitor and engine model
    initial begin
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (took) idx++;
            fifo_full_i = (bp_mode != 0) ? (((cyc / 3) % 2) == 1) : 1'b0;
            in_valid_i  = (idx < nin) && ((bp_mode == 0) || ($urandom_range(0, 1) == 1));
            in_dat_i    = (idx < nin) ? msg[idx] : 32'hDEADBEEF;
            @(negedge clk);
            took = in_valid_i && in_ready_o;
            if (took) consumed++;
            if (fifo_wr_en_o) wq.push_back(fifo_wr_dat_o);
            if (done_o) done_cnt++;
            if (eng_start_o && !prev_start) start_cnt++;
            prev_start = eng_start_o;
            if (rstn && !eng_rstn_o) rstn_low++;
            if (!eng_rstn_o) begin
                eng_ready_i = 1'b0;
                eng_cnt = 0;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) eng_ready_i = 1'b1;
            end else if (eng_start_o && eng_ready_i) begin
                eng_ready_i = 1'b0;
                eng_cnt = 6;
            end else begin
                eng_ready_i = 1'b1;
            end
        end
    end

    task automatic setup(input int n, input int bp, input logic [255:0] h);
        @(posedge clk); #2;
        nin = n; idx = 0; took = 1'b0; bp_mode = bp;
        consumed = 0; done_cnt = 0; start_cnt = 0; rstn_low = 0;
        wq.delete();
        eng_hash_i = h;
    endtask

    task automatic pulse_start(input logic [31:0] l);
        @(posedge clk); #2;
        start_i = 1'b1; len_i = l;
        @(posedge clk); #2;
        start_i = 1'b0;
    endtask

    // Start a message and wait (bounded) for its done pulse
    task automatic run_msg(input logic [31:0] l, input bit busy_start, output bit to);
        pulse_start(l);
        for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
            @(posedge clk);
            if (busy_start && k == 30) begin
                #2; start_i = 1'b1; len_i = 32'd0;
                @(posedge clk); #2; start_i = 1'b0;
            end
        end
        to = (done_cnt == 0);
        repeat (2) @(posedge clk);
        #3;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if ({in_ready_o, fifo_wr_en_o, eng_rstn_o, eng_start_o, busy_o, done_o} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 000000",
                {in_ready_o, fifo_wr_en_o, eng_rstn_o, eng_start_o, busy_o, done_o});
        end
        checks++;
        if (fifo_wr_dat_o !== 32'd0 || hash_o !== 256'd0 || blk_cnt_o !== 27'd0) begin
            errors++; $display("FAIL reset_data got dat=%h blk=%0d hash=%h", fifo_wr_dat_o, blk_cnt_o, hash_o);
        end
        @(posedge clk); #2;
        rstn = 1'b1;
        @(posedge clk); #3;
        checks++;
        if (eng_rstn_o !== 1'b1) begin
            errors++; $display("FAIL reset_eng_rstn_rise got %b want 1", eng_rstn_o);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_l0;
        bit to;
        logic [31:0] e, g;
        setup(0, 0, H_EMPTY);
        run_msg(32'd0, 1'b0, to);
        checks++; if (to) begin errors++; $display("FAIL l0_timeout got timeout want done"); end
        checks++; if (wq.size() != 16) begin errors++; $display("FAIL l0_nwords got %0d want 16", wq.size()); end
        for (int i = 0; i < 16; i++) begin
            e = (i == 0) ? 32'h8000_0000 : 32'h0;
            g = (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
            checks++;
            if (g !== e) begin errors++; $display("FAIL l0_word%0d got %h want %h", i, g, e); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL l0_done got %0d want 1", done_cnt); end
        checks++; if (hash_o !== H_EMPTY) begin errors++; $display("FAIL l0_hash got %h want %h", hash_o, H_EMPTY); end
        checks++; if (blk_cnt_o !== 27'd1) begin errors++; $display("FAIL l0_blk got %0d want 1", blk_cnt_o); end
        checks++; if (rstn_low != 2) begin errors++; $display("FAIL l0_eng_rst_len got %0d want 2", rstn_low); end
        checks++; if (start_cnt != 1 || consumed != 0) begin
            errors++; $display("FAIL l0_hs got starts=%0d cons=%0d want 1 0", start_cnt, consumed);
        end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL l0_busy got %b want 0", busy_o); end
    endtask

    task automatic test_l3;
        bit to;
        logic [31:0] e, g;
        msg[0] = 32'h616263FF;
        setup(1, 0, H_ABC);
        run_msg(32'd3, 1'b0, to);
        checks++; if (to) begin errors++; $display("FAIL l3_timeout got timeout want done"); end
        checks++; if (wq.size() != 16) begin errors++; $display("FAIL l3_nwords got %0d want 16", wq.size()); end
        for (int i = 0; i < 16; i++) begin
            e = (i == 0) ? 32'h6162_6380 : (i == 15) ? 32'h0000_0018 : 32'h0;
            g = (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
            checks++;
            if (g !== e) begin errors++; $display("FAIL l3_word%0d got %h want %h", i, g, e); end
        end
        checks++; if (consumed != 1) begin errors++; $display("FAIL l3_consumed got %0d want 1", consumed); end
        checks++; if (hash_o !== H_ABC) begin errors++; $display("FAIL l3_hash got %h want %h", hash_o, H_ABC); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL l3_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_l55;
        bit to;
        logic [31:0] e, g;
        for (int i = 0; i < 14; i++) msg[i] = 32'hA000_0000 | i;
        setup(14, 0, H_BP);
        run_msg(32'd55, 1'b0, to);
        checks++; if (to) begin errors++; $display("FAIL l55_timeout got timeout want done"); end
        checks++; if (wq.size() != 16) begin errors++; $display("FAIL l55_nwords got %0d want 16", wq.size()); end
        for (int i = 0; i < 16; i++) begin
            e = (i < 13) ? (32'hA000_0000 | i) : (i == 13) ? 32'hA000_0080 :
                (i == 15) ? 32'h0000_01B8 : 32'h0;
            g = (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
            checks++;
            if (g !== e) begin errors++; $display("FAIL l55_word%0d got %h want %h", i, g, e); end
        end
        checks++; if (consumed != 14) begin errors++; $display("FAIL l55_consumed got %0d want 14", consumed); end
        checks++; if (blk_cnt_o !== 27'd1) begin errors++; $display("FAIL l55_blk got %0d want 1", blk_cnt_o); end
    endtask

    // Two blocks; a start pulse while busy must be ignored
    task automatic test_l56_busy_start;
        bit to;
        logic [31:0] e, g;
        for (int i = 0; i < 14; i++) msg[i] = 32'hB000_0000 | i;
        setup(14, 0, H_ABC);
        run_msg(32'd56, 1'b1, to);
        checks++; if (to) begin errors++; $display("FAIL l56_timeout got timeout want done"); end
        checks++; if (wq.size() != 32) begin errors++; $display("FAIL l56_nwords got %0d want 32", wq.size()); end
        for (int i = 0; i < 32; i++) begin
            e = (i < 14) ? (32'hB000_0000 | i) : (i == 14) ? 32'h8000_0000 :
                (i == 31) ? 32'h0000_01C0 : 32'h0;
            g = (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
            checks++;
            if (g !== e) begin errors++; $display("FAIL l56_word%0d got %h want %h", i, g, e); end
        end
        checks++; if (start_cnt != 2) begin errors++; $display("FAIL l56_starts got %0d want 2", start_cnt); end
        checks++; if (blk_cnt_o !== 27'd2) begin errors++; $display("FAIL l56_blk got %0d want 2", blk_cnt_o); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL l56_done got %0d want 1", done_cnt); end
        checks++; if (rstn_low != 2) begin errors++; $display("FAIL l56_eng_rst_len got %0d want 2", rstn_low); end
    endtask

    task automatic test_backpressure;
        bit to;
        logic [31:0] e, g;
        for (int i = 0; i < 16; i++) msg[i] = 32'hC0DE_0000 | (i * 32'h101);
        setup(16, 1, H_BP);
        run_msg(32'd64, 1'b0, to);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout got timeout want done"); end
        checks++; if (wq.size() != 32) begin errors++; $display("FAIL bp_nwords got %0d want 32", wq.size()); end
        for (int i = 0; i < 32; i++) begin
            e = (i < 16) ? (32'hC0DE_0000 | (i * 32'h101)) : (i == 16) ? 32'h8000_0000 :
                (i == 31) ? 32'h0000_0200 : 32'h0;
            g = (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
            checks++;
            if (g !== e) begin errors++; $display("FAIL bp_word%0d got %h want %h", i, g, e); end
        end
        checks++; if (consumed != 16) begin errors++; $display("FAIL bp_consumed got %0d want 16", consumed); end
        checks++; if (hash_o !== H_BP) begin errors++; $display("FAIL bp_hash got %h want %h", hash_o, H_BP); end
        @(posedge clk); #2;
        bp_mode = 0;
    endtask

    // Abort while wib=7, then a clean "abc" message
    task automatic test_abort;
        bit to;
        for (int i = 0; i < 16; i++) msg[i] = 32'hD000_0000 | i;
        setup(16, 0, H_JUNK);
        pulse_start(32'd64);
        to = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            if (wq.size() >= 6) begin to = 1'b0; break; end
        end
        checks++; if (to) begin errors++; $display("FAIL abort_fill_timeout got timeout want 6 words"); end
        #2; abort_i = 1'b1;
        @(posedge clk); #2; abort_i = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        checks++; if (wq.size() != 7) begin errors++; $display("FAIL abort_nwords got %0d want 7", wq.size()); end
        checks++; if (rstn_low != 4) begin errors++; $display("FAIL abort_eng_rst_len got %0d want 4", rstn_low); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_done got %0d want 0", done_cnt); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy_o); end
        checks++; if (hash_o !== H_BP) begin errors++; $display("FAIL abort_hash got %h want %h", hash_o, H_BP); end
        checks++; if (blk_cnt_o !== 27'd0) begin errors++; $display("FAIL abort_blk got %0d want 0", blk_cnt_o); end
        msg[0] = 32'h616263FF;
        setup(1, 0, H_ABC);
        run_msg(32'd3, 1'b0, to);
        checks++; if (to) begin errors++; $display("FAIL abort_abc_timeout got timeout want done"); end
        checks++; if (hash_o !== H_ABC) begin errors++; $display("FAIL abort_abc_hash got %h want %h", hash_o, H_ABC); end
        checks++; if (wq.size() < 1 || wq[0] !== 32'h6162_6380) begin
            errors++; $display("FAIL abort_abc_word0 got %h want 61626380", (wq.size() > 0) ? wq[0] : 32'hx);
        end
    endtask

    task automatic test_async_reset;
        setup(0, 0, H_EMPTY);
        pulse_start(32'd0);
        repeat (8) @(posedge clk);
        #2; rstn = 1'b0;
        #1;
        checks++;
        if (eng_rstn_o !== 1'b0 || busy_o !== 1'b0 || fifo_wr_en_o !== 1'b0) begin
            errors++; $display("FAIL arst_ctrl got rstn=%b busy=%b wr=%b want 0 0 0", eng_rstn_o, busy_o, fifo_wr_en_o);
        end
        checks++;
        if (hash_o !== 256'd0 || blk_cnt_o !== 27'd0) begin
            errors++; $display("FAIL arst_data got blk=%0d hash=%h want 0", blk_cnt_o, hash_o);
        end
        @(posedge clk); #2; rstn = 1'b1;
        @(posedge clk); #3;
        checks++; if (eng_rstn_o !== 1'b1) begin errors++; $display("FAIL arst_release got %b want 1", eng_rstn_o); end
    endtask

    initial begin
        test_reset();
        test_l0();
        test_l3();
        test_l55();
        test_l56_busy_start();
        test_backpressure();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
